gshare_bht: RTL
===============

Name: gshare_bht

Overview:
- Next-generation branch history table: a global-history (gshare) direction predictor.
- Table index = PC index bits XOR the speculative global history register (GHR).
- Sits in fetch: predicts one branch per cycle. Commit/execute feeds back resolved outcomes.
- On mispredict, the GHR is restored from the history snapshot that travelled with the branch. The table is initialised by a multi-cycle sweep, so it maps onto single-write-port storage.

Parameters:
ENTRIES, 1024, number of counters; power of two, >= 16; IDX_W = log2(ENTRIES)
CTR_WIDTH, 2, saturating counter width, 1..4
GHR_WIDTH, 8, global history length, 1..IDX_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pred_valid  in  1  fetch requests a prediction this cycle
pred_pc  in  32  PC of branch being predicted
pred_ready  out  1  prediction accepted; = !init_busy && !upd_mispredict
pred_taken  out  1  predicted direction (combinational from inputs/state)
pred_ghr  out  GHR_WIDTH  history used to form pred index; carried down pipe
upd_valid  in  1  resolved branch update
upd_pc  in  32  PC of resolved branch
upd_ghr  in  GHR_WIDTH  pred_ghr snapshot captured when that branch was predicted
upd_taken  in  1  actual direction
upd_mispredict  in  1  direction mispredicted; qualified by upd_valid
init_busy  out  1  reset sweep in progress

Behaviour:
- Index: idx(pc, h) = pc[IDX_W+1:2] ^ {zero-extend h to IDX_W}.
  - pred_idx = idx(pred_pc, spec_ghr).
  - upd_idx = idx(upd_pc, upd_ghr).
- Counter arithmetic:
  - Taken: increment, saturating at 2^CTR_WIDTH-1.
  - Not taken: decrement, saturating at 0.
  - Predict taken iff counter >= 2^(CTR_WIDTH-1).
  - Reset value is weakly-not-taken, 2^(CTR_WIDTH-1)-1. For CTR_WIDTH=1 this is 0.
- FSM states: INIT and RUN.
- Reset:
  - rst=1 (any cycle, including mid-sweep or mid-operation) forces INIT, sweep_ptr=0, spec_ghr=0.
  - init_busy=1 and pred_ready=0 while rst is asserted.
- INIT:
  - Each cycle writes the reset value to entry sweep_ptr, then sweep_ptr++.
  - After writing entry ENTRIES-1, go to RUN. The first cycle with init_busy=0 is exactly ENTRIES cycles after rst deasserts.
  - During INIT: updates are dropped, pred_ready=0, pred_taken=0, pred_ghr=spec_ghr, spec_ghr held.
- RUN, update path:
  - If upd_valid, the counter at upd_idx steps by upd_taken at the clock edge. One update per cycle.
- RUN, prediction accept:
  - If pred_valid && pred_ready, spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred_taken}. For GHR_WIDTH=1, spec_ghr <= pred_taken.
- RUN, mispredict recovery:
  - If upd_valid && upd_mispredict, spec_ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}.
  - Recovery has priority over the prediction-accept shift. pred_ready=0 that cycle, so fetch must replay.
  - upd_mispredict without upd_valid is ignored.
- Forwarding:
  - If upd_valid and upd_idx == pred_idx in the same cycle, pred_taken is computed from the post-update counter value.
  - pred_ghr always equals the spec_ghr that formed pred_idx.
- Latency:
  - Prediction is zero-cycle (combinational read).
  - Update is visible in the table the cycle after upd_valid, or the same cycle via forwarding.
- No other outputs are registered. All state lives in spec_ghr, sweep_ptr, the FSM state and the counter array.

Decomposition:
- Shared package bp_pkg holds:
  - typedef bp_state_e {INIT, RUN}
  - functions ctr_next(ctr, taken) and ctr_taken(ctr), parameterised by CTR_WIDTH
  - reset-value constant expression
- One natural sub-module: bp_sat_ctr_update. It is combinational and computes the next counter value. It is instantiated twice: once for the write path and once for the forwarding path, so both share identical arithmetic.
- The GHR and sweep FSM stay in the top module.

Test Plan:
- Reset sweep: ENTRIES=16, pulse rst 1 cycle -> init_busy=1 for exactly 16 cycles. Then every PC predicts pred_taken=0. Updates issued during the sweep leave no effect.
- Saturation: CTR_WIDTH=2, GHR_WIDTH=1, fixed PC 0x100, no preds; 5 taken updates -> counter 3, pred_taken=1. Then 1 not-taken -> 2, still taken. Then 2 more not-taken -> 0, and 1 further not-taken stays at 0.
- GHR shift: accept preds with pred_taken=1,0,1 -> pred_ghr sequence 0x00, 0x01, 0x02, then spec_ghr=0x05.
- Mispredict recovery: spec_ghr=0x5A; upd_valid=1, upd_mispredict=1, upd_ghr=0x13, upd_taken=1, with pred_valid=1 the same cycle -> pred_ready=0, next-cycle pred_ghr=0x27.
- Forwarding: entry at counter 1; same-cycle update taken to the same index -> pred_taken=1 that cycle. A different index the same cycle -> pred_taken follows its own counter.
- Reset mid-operation: assert rst at sweep_ptr=7 and again in RUN with spec_ghr=0xFF -> sweep restarts from 0 (full ENTRIES cycles), spec_ghr=0, all counters return to the reset value.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and saturating-counter arithmetic for the gshare direction predictor.
// Counters are handled at a fixed 4-bit carrier width; callers pass their real width.
package bp_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_e;

   localparam int CTR_MAX_W = 4;

   function automatic logic [CTR_MAX_W-1:0] ctr_rst_val(input int w);
      return CTR_MAX_W'((1 << (w - 1)) - 1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                     input logic taken,
                                                     input int w);
      int c;
      int cmax;
      c    = int'(ctr);
      cmax = (1 << w) - 1;
      if (taken && (c < cmax)) begin
         c = c + 1;
      end else if (!taken && (c > 0)) begin
         c = c - 1;
      end
      return CTR_MAX_W'(c);
   endfunction

   function automatic logic ctr_taken(input logic [CTR_MAX_W-1:0] ctr, input int w);
      return int'(ctr) >= (1 << (w - 1));
   endfunction

endpackage

// File: rtl/bp_sat_ctr_update.sv
// Next value of one saturating direction counter; shared by the table write
// path and the same-cycle forwarding path so both step identically.
module bp_sat_ctr_update
   import bp_pkg::*;
#(
   parameter int CTR_WIDTH = 2
) (
   input  logic [CTR_WIDTH-1:0] ctr,
   input  logic                 taken,
   output logic [CTR_WIDTH-1:0] ctr_nxt
);

   always_comb begin
      ctr_nxt = CTR_WIDTH'(ctr_next(CTR_MAX_W'(ctr), taken, CTR_WIDTH));
   end

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch direction predictor: PC ^ speculative history indexes a table of
// saturating counters, initialised by a one-entry-per-cycle sweep after reset.
//
//   state | meaning
//   INIT  | sweeping reset value into the table, predictions and updates off
//   RUN   | predicting one branch per cycle, accepting resolved updates
module gshare_bht
   import bp_pkg::*;
#(
   parameter int ENTRIES   = 1024,
   parameter int CTR_WIDTH = 2,
   parameter int GHR_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pred_valid,
   input  logic [31:0]          pred_pc,
   output logic                 pred_ready,
   output logic                 pred_taken,
   output logic [GHR_WIDTH-1:0] pred_ghr,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [GHR_WIDTH-1:0] upd_ghr,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   output logic                 init_busy
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(ctr_rst_val(CTR_WIDTH));
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(ENTRIES - 1);

   bp_state_e              state_q, state_d;
   logic [IDX_W-1:0]       sweep_ptr_q, sweep_ptr_d;
   logic [GHR_WIDTH-1:0]   spec_ghr_q, spec_ghr_d;
   logic [CTR_WIDTH-1:0]   ctr_q [ENTRIES];

   logic [IDX_W-1:0]       pred_idx;
   logic [IDX_W-1:0]       upd_idx;
   logic [CTR_WIDTH-1:0]   pred_ctr;
   logic [CTR_WIDTH-1:0]   upd_ctr;
   logic [CTR_WIDTH-1:0]   upd_ctr_nxt;
   logic [CTR_WIDTH-1:0]   fwd_ctr_nxt;
   logic [CTR_WIDTH-1:0]   pred_ctr_eff;
   logic                   recover;
   logic                   upd_hit;
   logic                   wr_en;
   logic [IDX_W-1:0]       wr_idx;
   logic [CTR_WIDTH-1:0]   wr_data;
   logic                   unused_pc;

   assign pred_idx  = pred_pc[IDX_W+1:2] ^ IDX_W'(spec_ghr_q);
   assign upd_idx   = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
   assign pred_ctr  = ctr_q[pred_idx];
   assign upd_ctr   = ctr_q[upd_idx];
   assign recover   = upd_valid && upd_mispredict;
   assign upd_hit   = upd_valid && (upd_idx == pred_idx);
   assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

   bp_sat_ctr_update #(.CTR_WIDTH(CTR_WIDTH)) u_wr_upd (
      .ctr     (upd_ctr),
      .taken   (upd_taken),
      .ctr_nxt (upd_ctr_nxt)
   );

   bp_sat_ctr_update #(.CTR_WIDTH(CTR_WIDTH)) u_fwd_upd (
      .ctr     (pred_ctr),
      .taken   (upd_taken),
      .ctr_nxt (fwd_ctr_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         sweep_ptr_q <= '0;
         spec_ghr_q  <= '0;
      end else begin
         state_q     <= state_d;
         sweep_ptr_q <= sweep_ptr_d;
         spec_ghr_q  <= spec_ghr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sweep_ptr_d = sweep_ptr_q;
      spec_ghr_d  = spec_ghr_q;
      case (state_q)
         INIT: begin
            sweep_ptr_d = sweep_ptr_q + 1'b1;
            if (sweep_ptr_q == IDX_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Recovery beats the speculative shift; fetch replays that cycle.
            if (recover) begin
               spec_ghr_d = GHR_WIDTH'({upd_ghr, upd_taken});
            end else if (pred_valid && pred_ready) begin
               spec_ghr_d = GHR_WIDTH'({spec_ghr_q, pred_taken});
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      init_busy    = rst || (state_q == INIT);
      pred_ready   = !init_busy && !recover;
      pred_ctr_eff = upd_hit ? fwd_ctr_nxt : pred_ctr;
      pred_taken   = !init_busy && ctr_taken(CTR_MAX_W'(pred_ctr_eff), CTR_WIDTH);
      pred_ghr     = spec_ghr_q;
      wr_en        = 1'b0;
      wr_idx       = upd_idx;
      wr_data      = upd_ctr_nxt;
      if (!rst) begin
         if (state_q == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_ptr_q;
            wr_data = CTR_RST;
         end else begin
            wr_en = upd_valid;
         end
      end
   end

   // Single write port: either the sweep or the resolved update, never both.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ctr_q[wr_idx] <= wr_data;
      end
   end

endmodule
